fpu_clk_rst_seq: RTL

FPU_CLK_RST_SEQ -- requirements
Module: fpu_clk_rst_seq

---
 rtl/fpu_clk_rst_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fpu_clk_rst_seq.sv
// FPU cluster clock/reset sequencer.
// Brings the cluster header out of reset in three timed phases (clock
// enable, then reset release, then run), supports a timed debug-init
// pulse, and optionally a clock-stop handshake.
// Optional feature macro: FPU_CLK_SEQ_STOP_EN enables STOPPED and the
// stop_req/stop_ack handshake; without it stop_req is ignored and
// stop_ack stays low.
module fpu_clk_rst_seq #(
    parameter int unsigned CKEN_DLY = 8,
    parameter int unsigned GRST_DLY = 16,
    parameter int unsigned DBG_CYC  = 4
) (
    input  logic       gclk,
    input  logic       arst_l,
    input  logic       se,
    input  logic       dbg_req,
    input  logic       stop_req,
    output logic       cluster_cken,
    output logic       grst_l,
    output logic       gdbginit_l,
    output logic       stop_ack,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_CKEN_WAIT = 3'd1,
        ST_GRST_WAIT = 3'd2,
        ST_RUN       = 3'd3,
        ST_DBGINIT   = 3'd4,
        ST_STOPPED   = 3'd5
    } state_e;

    localparam logic [4:0] CKEN_LAST = 5'(CKEN_DLY - 1);
    localparam logic [4:0] GRST_LAST = 5'(GRST_DLY - 1);
    localparam logic [4:0] DBG_LAST  = 5'(DBG_CYC - 1);

    logic [1:0] r_sync;
    logic       w_rst_sync_l;
    state_e     r_state;
    state_e     w_state_nxt;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_nxt;
    logic       r_cken;
    logic       w_cken_nxt;
    logic       r_grst_l;
    logic       w_grst_l_nxt;
    logic       r_dbginit_l;
    logic       w_dbginit_l_nxt;
    logic       r_stop_ack;
    logic       w_stop_ack_nxt;

`ifndef FPU_CLK_SEQ_STOP_EN
    logic w_unused_stop_req;
    assign w_unused_stop_req = stop_req;
`endif

    // Two-flop synchroniser for reset release; assertion is immediate.
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) r_sync <= '0;
        else         r_sync <= {r_sync[0], 1'b1};
    end

    assign w_rst_sync_l = r_sync[1];

    // State, counter and registered header controls.
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_cken      <= 1'b0;
            r_grst_l    <= 1'b0;
            r_dbginit_l <= 1'b0;
            r_stop_ack  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cken      <= w_cken_nxt;
            r_grst_l    <= w_grst_l_nxt;
            r_dbginit_l <= w_dbginit_l_nxt;
            r_stop_ack  <= w_stop_ack_nxt;
        end
    end

    // Next-state and next-output decode; counter clears on every state entry.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 5'd1;
        w_cken_nxt      = r_cken;
        w_grst_l_nxt    = r_grst_l;
        w_dbginit_l_nxt = r_dbginit_l;
        w_stop_ack_nxt  = r_stop_ack;
        case (r_state)
            ST_RESET: begin
                w_cnt_nxt       = '0;
                w_cken_nxt      = 1'b0;
                w_grst_l_nxt    = 1'b0;
                w_dbginit_l_nxt = 1'b0;
                w_stop_ack_nxt  = 1'b0;
                if (w_rst_sync_l) w_state_nxt = ST_CKEN_WAIT;
            end
            ST_CKEN_WAIT: begin
                if (r_cnt == CKEN_LAST) begin
                    w_cken_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GRST_WAIT;
                end
            end
            ST_GRST_WAIT: begin
                if (r_cnt == GRST_LAST) begin
                    w_grst_l_nxt    = 1'b1;
                    w_dbginit_l_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (dbg_req) begin
                    w_dbginit_l_nxt = 1'b0;
                    w_state_nxt     = ST_DBGINIT;
                end
`ifdef FPU_CLK_SEQ_STOP_EN
                else if (stop_req) begin
                    w_cken_nxt  = 1'b0;
                    w_state_nxt = ST_STOPPED;
                end
`endif
            end
            ST_DBGINIT: begin
                if (r_cnt == DBG_LAST) begin
                    w_dbginit_l_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_RUN;
                end
            end
`ifdef FPU_CLK_SEQ_STOP_EN
            ST_STOPPED: begin
                w_cnt_nxt = '0;
                if (!stop_req) begin
                    w_cken_nxt     = 1'b1;
                    w_stop_ack_nxt = 1'b0;
                    w_state_nxt    = ST_RUN;
                end else begin
                    w_stop_ack_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_cnt_nxt       = '0;
                w_cken_nxt      = 1'b0;
                w_grst_l_nxt    = 1'b0;
                w_dbginit_l_nxt = 1'b0;
                w_stop_ack_nxt  = 1'b0;
                w_state_nxt     = ST_RESET;
            end
        endcase
    end

    // Scan enable overrides only the clock enable, never state.
    assign cluster_cken = r_cken | se;
    assign grst_l       = r_grst_l;
    assign gdbginit_l   = r_dbginit_l;
    assign stop_ack     = r_stop_ack;
    assign seq_state    = r_state;

endmodule
